// File: rtl/mesh_rx_arbiter_if.sv
// Handshake bundle between the mesh link IRS outputs, the receive arbiter and the node core.
// The slave modport is the arbiter's view; master is the view of whatever drives the links and the core.
interface mesh_rx_arbiter_if #(
  parameter int N_IN   = 14,
  parameter int PYLD_W = 47
);
  logic [N_IN-1:0]        in_vld;
  logic [N_IN-1:0]        in_rdy;
  logic [N_IN*PYLD_W-1:0] in_pyld;
  logic                   out_vld;
  logic                   out_rdy;
  logic [PYLD_W-1:0]      out_pyld;

  modport slave (
    input  in_vld, in_pyld, out_rdy,
    output in_rdy, out_vld, out_pyld
  );

  modport master (
    output in_vld, in_pyld, out_rdy,
    input  in_rdy, out_vld, out_pyld
  );
endinterface

// File: rtl/mesh_rx_arbiter.sv
// Mesh receive arbiter: strict-QoS, per-class round-robin pick of one link channel per cycle into an ejection FIFO.
// Optional statistics (transfer counter, sticky misroute flag) are built when MESH_RX_STAT_EN is defined.
module mesh_rx_arbiter #(
  parameter int N_IN       = 14,
  parameter int TYPE_W     = 2,
  parameter int ID_W       = 6,
  parameter int FLIT_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int NODE_ID    = 0,
  parameter int PYLD_W     = 1 + TYPE_W + 2 * ID_W + FLIT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mesh_rx_arbiter_if.slave      bus,
  output logic [15:0]           stat_cnt,
  output logic                  stat_mis
);

  localparam int IDX_W = $clog2(N_IN);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;

  logic [PYLD_W-1:0] pyld_arr_s [N_IN];
  logic [PYLD_W-1:0] push_pyld_s;
  logic [N_IN-1:0]   hi_req_s, lo_req_s, gnt_oh_s;
  logic [IDX_W-1:0]  gnt_idx_s;
  logic              any_hi_s, any_req_s, full_s, push_s, pop_s;

  logic [IDX_W-1:0]  rr_hi_q, rr_hi_d, rr_lo_q, rr_lo_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PYLD_W-1:0] mem_q [FIFO_DEPTH];
  logic [PYLD_W-1:0] mem_d [FIFO_DEPTH];
  logic              en_q, en_d;

  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_IN-1:0] req, input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] pick;
    logic             found;
    logic [IDX_W:0]   idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      idx = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (idx >= (IDX_W + 1)'(N_IN)) begin
        idx = idx - (IDX_W + 1)'(N_IN);
      end else begin
        idx = idx;
      end
      if (!found && req[idx[IDX_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[IDX_W-1:0];
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] g);
    logic [IDX_W-1:0] n;
    if (g == IDX_W'(N_IN - 1)) begin
      n = '0;
    end else begin
      n = g + {{(IDX_W-1){1'b0}}, 1'b1};
    end
    return n;
  endfunction

  // Unpack channels and split requests by QoS class
  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      pyld_arr_s[i] = bus.in_pyld[i*PYLD_W +: PYLD_W];
      hi_req_s[i]   = bus.in_vld[i] &  pyld_arr_s[i][PYLD_W-1];
      lo_req_s[i]   = bus.in_vld[i] & ~pyld_arr_s[i][PYLD_W-1];
    end
  end

  // Grant selection; en_q keeps in_rdy low from reset until the first clock after release
  always_comb begin
    any_hi_s  = |hi_req_s;
    any_req_s = |bus.in_vld;
    if (any_hi_s) begin
      gnt_idx_s = rr_pick(hi_req_s, rr_hi_q);
    end else begin
      gnt_idx_s = rr_pick(lo_req_s, rr_lo_q);
    end
    gnt_oh_s = '0;
    if (any_req_s) begin
      gnt_oh_s[gnt_idx_s] = 1'b1;
    end else begin
      gnt_oh_s = '0;
    end
    full_s      = (count_q == CW'(FIFO_DEPTH));
    bus.in_rdy  = gnt_oh_s & {N_IN{~full_s & en_q}};
    push_s      = any_req_s & ~full_s & en_q;
    push_pyld_s = pyld_arr_s[gnt_idx_s];
    pop_s       = bus.out_vld & bus.out_rdy;
  end

  // Next state for class pointers and ejection FIFO
  always_comb begin
    en_d     = 1'b1;
    rr_hi_d  = rr_hi_q;
    rr_lo_d  = rr_lo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (push_s) begin
      if (any_hi_s) begin
        rr_hi_d = rr_next(gnt_idx_s);
      end else begin
        rr_lo_d = rr_next(gnt_idx_s);
      end
      mem_d[wr_ptr_q] = push_pyld_s;
      wr_ptr_d        = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q     <= 1'b0;
      rr_hi_q  <= '0;
      rr_lo_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      en_q     <= en_d;
      rr_hi_q  <= rr_hi_d;
      rr_lo_q  <= rr_lo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign bus.out_vld  = (count_q != {CW{1'b0}});
  assign bus.out_pyld = mem_q[rd_ptr_q];

`ifdef MESH_RX_STAT_EN
  logic [15:0] stat_cnt_q, stat_cnt_d;
  logic        stat_mis_q, stat_mis_d;

  // Transfer counter and sticky misroute flag; misrouted packets are still queued
  always_comb begin
    stat_cnt_d = stat_cnt_q;
    stat_mis_d = stat_mis_q;
    if (push_s) begin
      stat_cnt_d = stat_cnt_q + 16'd1;
      if (push_pyld_s[FLIT_W +: ID_W] != ID_W'(NODE_ID)) begin
        stat_mis_d = 1'b1;
      end else begin
        stat_mis_d = stat_mis_q;
      end
    end else begin
      stat_cnt_d = stat_cnt_q;
    end
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cnt_q <= 16'h0000;
      stat_mis_q <= 1'b0;
    end else begin
      stat_cnt_q <= stat_cnt_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign stat_cnt = stat_cnt_q;
  assign stat_mis = stat_mis_q;
`else
  assign stat_cnt = 16'h0000;
  assign stat_mis = 1'b0;
`endif

endmodule
